// File: rtl/lzrw1_pkg.sv
// Shared field positions, length bias and FSM state encoding for the LZRW1 decompressor.
package lzrw1_pkg;

  localparam int LEN_BIAS   = 3;
  localparam int LEN_MSB    = 15;
  localparam int LEN_LSB    = 12;
  localparam int OFFSET_MSB = 11;
  localparam int OFFSET_LSB = 0;
  localparam int LIT_MSB    = 7;
  localparam int LIT_LSB    = 0;
  localparam int LEN_CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIT  = 2'd1,
    COPY = 2'd2
  } state_e;

endpackage

// File: rtl/lzrw1_history_buf.sv
// Circular byte history: writes are staged one cycle in a pending register, and reads of that
// pending slot are forwarded, so the newest byte is visible without a combinational write-to-read path.
module lzrw1_history_buf
  import lzrw1_pkg::*;
#(
  parameter int HISTORY_SIZE = 256,
  localparam int AW = $clog2(HISTORY_SIZE)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem [HISTORY_SIZE];
  logic          pend_valid_q, pend_valid_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]    pend_data_q, pend_data_d;

  always_comb begin
    pend_valid_d = wr_en;
    pend_addr_d  = wr_addr;
    pend_data_d  = wr_data;
  end

  // Contents are never cleared; the staged write still commits on a reset edge.
  always_ff @(posedge clock) begin
    if (pend_valid_q) begin
      mem[pend_addr_q] <= pend_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
    end
    pend_addr_q <= pend_addr_d;
    pend_data_q <= pend_data_d;
  end

  assign rd_data = (pend_valid_q && (pend_addr_q == rd_addr)) ? pend_data_q : mem[rd_addr];

endmodule

// File: rtl/lzrw1_decompressor.sv
// LZRW1 decompressor: accepts one literal or copy item when idle and emits one byte per cycle,
// writing every emitted byte back into the history for later back-references.
module lzrw1_decompressor
  import lzrw1_pkg::*;
#(
  parameter int HISTORY_SIZE = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic        control_word_in,
  input  logic        data_in_valid,
  output logic [7:0]  decompressed_byte,
  output logic        out_valid,
  output logic        decompressor_busy
);

  localparam int AW = $clog2(HISTORY_SIZE);

  state_e               state_q, state_d;
  logic [15:0]          item_q, item_d;
  logic [LEN_CNT_W-1:0] len_q, len_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [7:0]           byte_q, byte_d;
  logic                 out_valid_q, out_valid_d;

  logic [11:0]          offset_full;
  logic [AW-1:0]        rd_addr;
  logic [7:0]           rd_data;
  logic                 wr_en;
  logic [7:0]           wr_data;

  assign offset_full = item_q[OFFSET_MSB:OFFSET_LSB];
  // Offsets beyond the history depth simply wrap.
  assign rd_addr     = wr_ptr_q - offset_full[AW-1:0];

  lzrw1_history_buf #(
    .HISTORY_SIZE(HISTORY_SIZE)
  ) u_history (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    item_d      = item_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    byte_d      = byte_q;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_data     = rd_data;
    case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          item_d  = data_in;
          len_d   = LEN_CNT_W'(data_in[LEN_MSB:LEN_LSB]) + LEN_CNT_W'(LEN_BIAS);
          state_d = control_word_in ? COPY : LIT;
        end
      end
      LIT: begin
        wr_en       = 1'b1;
        wr_data     = item_q[LIT_MSB:LIT_LSB];
        byte_d      = item_q[LIT_MSB:LIT_LSB];
        out_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + AW'(1);
        state_d     = IDLE;
      end
      COPY: begin
        wr_en       = 1'b1;
        byte_d      = rd_data;
        out_valid_d = 1'b1;
        wr_ptr_d    = wr_ptr_q + AW'(1);
        len_d       = len_q - LEN_CNT_W'(1);
        if (len_q == LEN_CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      item_q      <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      byte_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      item_q      <= item_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      byte_q      <= byte_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign decompressed_byte = byte_q;
  assign out_valid         = out_valid_q;
  assign decompressor_busy = (state_q != IDLE);

endmodule

// File: tb/tb_lzrw1_decompressor.sv
// Directed bench for lzrw1_decompressor: table of items with expected byte strings, plus
// reset-mid-copy and history-wrap sequences.
module tb_lzrw1_decompressor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        control_word_in = 1'b0;
  logic        data_in_valid = 1'b0;
  logic [7:0]  decompressed_byte;
  logic        out_valid;
  logic        decompressor_busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_byte = 8'h00;

  typedef struct {
    logic          cw;
    logic [15:0]   data;
    int            n;
    logic [143:0]  exp;
  } vec_t;

  vec_t vecs [13];

  lzrw1_decompressor #(.HISTORY_SIZE(256)) dut (
    .clock             (clock),
    .reset             (reset),
    .data_in           (data_in),
    .control_word_in   (control_word_in),
    .data_in_valid     (data_in_valid),
    .decompressed_byte (decompressed_byte),
    .out_valid         (out_valid),
    .decompressor_busy (decompressor_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one item, hold junk on the inputs while busy, and check every emitted byte and busy length.
  task automatic run_item(input string name, input logic cw, input logic [15:0] d,
                          input int n, input logic [143:0] exp);
    int  idx;
    int  busy_cyc;
    bit  done;
    @(negedge clock);
    data_in         = d;
    control_word_in = cw;
    data_in_valid   = 1'b1;
    @(posedge clock);
    #1;
    check({name, " accept busy"}, 32'(decompressor_busy), 32'd1);
    check({name, " accept out_valid"}, 32'(out_valid), 32'd0);
    check({name, " hold byte"}, 32'(decompressed_byte), 32'(last_byte));
    data_in         = 16'($urandom);
    control_word_in = 1'($urandom);
    idx      = 0;
    busy_cyc = 1;
    done     = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        if (idx < n) begin
          check($sformatf("%s byte%0d", name, idx), 32'(decompressed_byte),
                32'(exp[8*(n-1-idx) +: 8]));
        end else begin
          check($sformatf("%s extra out_valid", name), 32'(out_valid), 32'd0);
        end
        last_byte = decompressed_byte;
        idx++;
      end
      if (decompressor_busy) begin
        busy_cyc++;
        data_in         = 16'($urandom);
        control_word_in = 1'($urandom);
      end else begin
        data_in_valid = 1'b0;
        done          = 1'b1;
      end
    end
    data_in_valid = 1'b0;
    if (!done) begin
      check({name, " busy timeout"}, 32'(decompressor_busy), 32'd0);
    end
    check({name, " byte count"}, 32'(idx), 32'(n));
    check({name, " busy cycles"}, 32'(busy_cyc), 32'(n));
    $display("item %s cw=%0d data=%h bytes=%0d busy=%0d", name, cw, d, idx, busy_cyc);
  endtask

  initial begin
    logic [143:0] e;
    vecs[0]  = '{1'b0, 16'h0061, 1, 144'("a")};
    vecs[1]  = '{1'b0, 16'h0062, 1, 144'("b")};
    vecs[2]  = '{1'b0, 16'h0063, 1, 144'("c")};
    vecs[3]  = '{1'b1, 16'h0003, 3, 144'("abc")};
    vecs[4]  = '{1'b0, 16'h5A33, 1, 144'("3")};
    vecs[5]  = '{1'b0, 16'h0078, 1, 144'("x")};
    vecs[6]  = '{1'b1, 16'h2001, 5, 144'("xxxxx")};
    vecs[7]  = '{1'b0, 16'h0077, 1, 144'("w")};
    vecs[8]  = '{1'b0, 16'h0078, 1, 144'("x")};
    vecs[9]  = '{1'b0, 16'h0079, 1, 144'("y")};
    vecs[10] = '{1'b0, 16'h007A, 1, 144'("z")};
    vecs[11] = '{1'b1, 16'hF004, 18, 144'("wxyzwxyzwxyzwxyzwx")};
    vecs[12] = '{1'b1, 16'h1002, 4, 144'("wxwx")};

    repeat (3) @(posedge clock);
    #1;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(decompressor_busy), 32'd0);
    check("reset byte", 32'(decompressed_byte), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_item($sformatf("vec%0d", i), vecs[i].cw, vecs[i].data, vecs[i].n, vecs[i].exp);
    end

    // Reset in the middle of a long copy.
    run_item("rst_w", 1'b0, 16'h0077, 1, 144'("w"));
    run_item("rst_x", 1'b0, 16'h0078, 1, 144'("x"));
    run_item("rst_y", 1'b0, 16'h0079, 1, 144'("y"));
    run_item("rst_z", 1'b0, 16'h007A, 1, 144'("z"));
    @(negedge clock);
    data_in         = 16'hF004;
    control_word_in = 1'b1;
    data_in_valid   = 1'b1;
    @(posedge clock);
    #1;
    data_in_valid = 1'b0;
    e = 144'("wxyz");
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("midcopy valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("midcopy byte%0d", k), 32'(decompressed_byte), 32'(e[8*(3-k) +: 8]));
    end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset busy", 32'(decompressor_busy), 32'd0);
    check("midreset byte", 32'(decompressed_byte), 32'd0);
    $display("item midreset valid=%0d busy=%0d", out_valid, decompressor_busy);
    @(negedge clock);
    reset = 1'b0;
    last_byte = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      check($sformatf("postreset quiet%0d", k), 32'(out_valid | decompressor_busy), 32'd0);
    end
    run_item("after_reset", 1'b0, 16'h0041, 1, 144'("A"));

    // Fill well past the history depth, then copy from offset 256 (wraps to the oldest slot).
    for (int k = 0; k < 300; k++) begin
      e = 144'((k * 7 + 1) & 255);
      run_item($sformatf("fill%0d", k), 1'b0, 16'((k * 7 + 1) & 255), 1, e);
    end
    e = 144'({8'd53, 8'd60, 8'd67});
    run_item("wrap_off256", 1'b1, 16'h0100, 3, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
